control_cmd_heartbeat_tx: RTL



---
 rtl/params_pkg.sv | 8 +
 rtl/heartbeat_tick_timer.sv | 16 +
 rtl/control_cmd_heartbeat_tx.sv | 100 ++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// params_pkg: shared watchdog keepalive constants and heartbeat transmitter state encoding
package params_pkg;
  localparam int WATCHDOG_SIGNATURE_BITS = 32;
  localparam logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = 32'hDEADBEEF;
  localparam logic [7:0] CMD_WATCHDOG = 8'h57;
  localparam int HEARTBEAT_TICKS = 1000000;
  typedef enum logic [1:0] {IDLE, SEND_CMD, SEND_SIG, DONE} hb_tx_state_e;
endpackage

// File: rtl/heartbeat_tick_timer.sv
// heartbeat_tick_timer: reloadable down-counter with a one-cycle expiry pulse every TICKS cycles
module heartbeat_tick_timer #(
  parameter int TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(TICKS);
  localparam logic [W-1:0] RELOAD = W'(TICKS - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire_o = en_i && cnt_q == '0;
  always_comb cnt_d = (!en_i || expire_o) ? RELOAD : cnt_q - W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? RELOAD : cnt_d;
endmodule

// File: rtl/control_cmd_heartbeat_tx.sv
// control_cmd_heartbeat_tx: periodic keepalive frame (opcode + signature, MSB first) onto the control byte stream
// Optional HEARTBEAT_FAULT_INJECT_EN adds an inhibit input that discards timer expiries.
module control_cmd_heartbeat_tx #(
  parameter int HEARTBEAT_TICKS = params_pkg::HEARTBEAT_TICKS,
  parameter int WATCHDOG_SIGNATURE_BITS = params_pkg::WATCHDOG_SIGNATURE_BITS,
  parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = params_pkg::WATCHDOG_SIGNATURE_PATTERN,
  parameter logic [7:0] CMD_OPCODE = params_pkg::CMD_WATCHDOG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       kick,
  input  logic       tx_ready,
`ifdef HEARTBEAT_FAULT_INJECT_EN
  input  logic       inhibit,
`endif
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_count
);
  import params_pkg::*;
  localparam int SIGBYTES = WATCHDOG_SIGNATURE_BITS / 8;
  localparam int IW = SIGBYTES > 1 ? $clog2(SIGBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SIGBYTES - 1);
  hb_tx_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] data_q, data_d, ovr_q, ovr_d;
  logic valid_q, valid_d, pend_q, pend_d, expire, req, accept;
  logic [WATCHDOG_SIGNATURE_BITS-1:0] pat;
  heartbeat_tick_timer #(.TICKS(HEARTBEAT_TICKS)) u_timer (
    .clk(clk), .rst(reset), .en_i(enable), .expire_o(expire)
  );
`ifdef HEARTBEAT_FAULT_INJECT_EN
  assign req = (expire && !inhibit) || kick;
`else
  assign req = expire || kick;
`endif
  assign pat = WATCHDOG_SIGNATURE_PATTERN;
  assign accept = valid_q && tx_ready;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    valid_d = valid_q;
    ovr_d = ovr_q;
    pend_d = pend_q && enable;
    case (state_q)
      IDLE: if (req || pend_d) begin
        state_d = SEND_CMD;
        valid_d = 1'b1;
        data_d = CMD_OPCODE;
        pend_d = 1'b0;
      end
      SEND_CMD: if (accept) begin
        state_d = SEND_SIG;
        idx_d = LAST;
        data_d = pat[{LAST, 3'b000} +: 8];
      end
      SEND_SIG: if (accept) begin
        if (idx_q == '0) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else begin
          idx_d = idx_q - IW'(1);
          data_d = pat[{idx_d, 3'b000} +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
    // one request can wait in pending; further ones while busy are dropped and counted
    if (state_q != IDLE && req) begin
      if (!pend_d) pend_d = 1'b1;
      else if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      pend_q <= pend_d;
    end
  end
  assign tx_data = data_q;
  assign tx_valid = valid_q;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign overrun_count = ovr_q;
endmodule
